// File: rtl/alu_share_arbiter_pkg.sv
// ALU share arbiter package: ALUControl codes, FSM state encoding, illegal-code check.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arb_pkg;

    // Core ALUControl encoding
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Codes 1010..1111 have no operation assigned.
    function automatic logic alu_ctrl_illegal(input logic [3:0] ctrl);
        return (ctrl >= 4'b1010);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared ALU and its consumer.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the response.
// Ports: req_valid/req_ready/req_a/req_b/req_ctrl (per requester, packed by index),
//        rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_err, plus rsp_zero/rsp_neg
//        when ALU_ARB_FLAGS_EN is defined.
interface alu_share_arbiter_if #(
    parameter int W    = 32,
    parameter int NREQ = 2
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_ctrl;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
`ifdef ALU_ARB_FLAGS_EN
    logic              rsp_zero;
    logic              rsp_neg;
`endif

    // master: requesters + response consumer; slave: the arbiter
    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
`ifdef ALU_ARB_FLAGS_EN
        , input rsp_zero, rsp_neg
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
`ifdef ALU_ARB_FLAGS_EN
        , output rsp_zero, rsp_neg
`endif
    );

endinterface

// File: rtl/alu_share_arbiter_alu_core.sv
// Combinational ALU: (a, b, ctrl) -> (result, err); illegal codes give result 0, err 1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   ctrl,
    output logic [W-1:0] result,
    output logic         err
);
    localparam int SHW = $clog2(W);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        err    = alu_ctrl_illegal(ctrl);
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SLTU: result = {{(W-1){1'b0}}, (a < b)};
            ALU_SRA:  result = W'($signed(a) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin shares one registered ALU among NREQ valid/ready requesters; tagged response.
// Latency: handshake at edge t -> rsp_valid seen at edge t+2; one op per 3 cycles max.
// Backpressure: response held in RESP until rsp_ready; no request accepted meanwhile.
// Ports: clk, reset (sync, active-high), bus (alu_share_arbiter_if.slave).
// Optional: ALU_ARB_FLAGS_EN adds registered rsp_zero/rsp_neg (0 when rsp_err).
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [IDW-1:0]  last_grant;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] req_rdy;
    logic            capture;
    logic            exec;
    logic            rsp_vld;

    logic [W-1:0]    a_q, b_q;
    logic [3:0]      ctrl_q;
    logic [IDW-1:0]  id_q;

    logic [IDW-1:0]  rsp_id_q;
    logic [W-1:0]    rsp_result_q;
    logic            rsp_err_q;

    logic [W-1:0]    alu_result;
    logic            alu_err;

    // Search starts one past the last winner so continuously valid
    // requesters rotate; a lone requester wraps back to itself.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_rdy   = '0;
        capture   = 1'b0;
        exec      = 1'b0;
        rsp_vld   = 1'b0;
        case (state)
            ST_IDLE: begin
                // ready is only raised toward a valid requester, so ready implies handshake
                if (gnt_found && !reset) begin
                    req_rdy[gnt_idx] = 1'b1;
                    capture          = 1'b1;
                    state_nxt        = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec      = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_vld = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IDW'(NREQ - 1);
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            id_q       <= '0;
        end else if (capture) begin
            last_grant <= gnt_idx;
            a_q        <= bus.req_a[gnt_idx*W +: W];
            b_q        <= bus.req_b[gnt_idx*W +: W];
            ctrl_q     <= bus.req_ctrl[gnt_idx*4 +: 4];
            id_q       <= gnt_idx;
        end
    end

    alu_core #(.W(W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .ctrl   (ctrl_q),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else if (exec) begin
            rsp_id_q     <= id_q;
            rsp_result_q <= alu_result;
            rsp_err_q    <= alu_err;
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic rsp_zero_q;
    logic rsp_neg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_zero_q <= 1'b0;
            rsp_neg_q  <= 1'b0;
        end else if (exec) begin
            // illegal ops report no flags even though their result is 0
            rsp_zero_q <= (alu_result == '0) && !alu_err;
            rsp_neg_q  <= alu_result[W-1] && !alu_err;
        end
    end

    assign bus.rsp_zero = rsp_zero_q;
    assign bus.rsp_neg  = rsp_neg_q;
`else
    // flag outputs are not present in this build
`endif

    assign bus.req_ready  = req_rdy;
    assign bus.rsp_valid  = rsp_vld;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with three requesters and 32-bit operands.
// Latency: checks accept -> EXEC -> RESP timing on every operation.
// Backpressure: holds rsp_ready low in RESP and checks the response stays put.
module tb_alu_share_arbiter;
    localparam int W    = 32;
    localparam int NREQ = 3;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_share_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

    alu_share_arbiter #(.W(W), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic v);
        bus.req_a[idx*W +: W]    = a;
        bus.req_b[idx*W +: W]    = b;
        bus.req_ctrl[idx*4 +: 4] = c;
        bus.req_valid[idx]       = v;
    endtask

    // Lone request from idx; called at a negedge with the FSM in IDLE, returns in IDLE.
    task automatic do_op(input string tag, input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c,
                         input logic [31:0] er, input logic ee);
        set_req(idx, a, b, c, 1'b1);
        #1;
        check({tag, "_grant"}, 64'(bus.req_ready), 64'(1) << idx);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        check({tag, "_exec_vld"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, "_exec_rdy"}, 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        check({tag, "_vld"}, 64'(bus.rsp_valid), 64'(1));
        check({tag, "_res"}, 64'(bus.rsp_result), 64'(er));
        check({tag, "_id"},  64'(bus.rsp_id), 64'(idx));
        check({tag, "_err"}, 64'(bus.rsp_err), 64'(ee));
`ifdef ALU_ARB_FLAGS_EN
        check({tag, "_zero"}, 64'(bus.rsp_zero), 64'((er == 32'd0) && !ee));
        check({tag, "_neg"},  64'(bus.rsp_neg),  64'(er[31] && !ee));
`endif
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_done"}, 64'(bus.rsp_valid), 64'(0));
    endtask

    logic [31:0] rr_res [3];
    int ng;
    int nr;

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            check("idle_rdy", 64'(bus.req_ready), 64'(0));
            check("idle_vld", 64'(bus.rsp_valid), 64'(0));
            check("idle_res", 64'(bus.rsp_result), 64'(0));
            check("idle_id",  64'(bus.rsp_id), 64'(0));
            check("idle_err", 64'(bus.rsp_err), 64'(0));
            @(negedge clk);
        end

        // single ops and edge cases
        do_op("sub",   0, 32'd7,          32'd5, 4'b0001, 32'd2,          1'b0);
        do_op("sra",   1, 32'h8000_0000,  32'd4, 4'b1001, 32'hF800_0000,  1'b0);
        do_op("srl",   2, 32'h8000_0000,  32'd4, 4'b0111, 32'h0800_0000,  1'b0);
        do_op("slt",   0, 32'hFFFF_FFFF,  32'd1, 4'b0101, 32'd1,          1'b0);
        do_op("sltu",  1, 32'hFFFF_FFFF,  32'd1, 4'b1000, 32'd0,          1'b0);
        do_op("addw",  0, 32'hFFFF_FFFF,  32'd1, 4'b0000, 32'd0,          1'b0);
        do_op("ill",   1, 32'd9,          32'd3, 4'b1100, 32'd0,          1'b1);
        do_op("sll",   0, 32'd1,          32'd33, 4'b0110, 32'd2,         1'b0);
        do_op("and",   0, 32'h0000_F0F0,  32'h0000_FF00, 4'b0010, 32'h0000_F000, 1'b0);
        do_op("or",    2, 32'h0000_00F0,  32'h0000_000F, 4'b0011, 32'h0000_00FF, 1'b0);

        // round robin: last grant was 2, so order is 0,1,2,0,1,2
        rr_res[0] = 32'd3;
        rr_res[1] = 32'd7;
        rr_res[2] = 32'h0F;
        set_req(0, 32'd1,  32'd2,  4'b0000, 1'b1);
        set_req(1, 32'd10, 32'd3,  4'b0001, 1'b1);
        set_req(2, 32'hF0, 32'hFF, 4'b0100, 1'b1);
        bus.rsp_ready = 1'b1;
        ng = 0;
        nr = 0;
        for (int cyc = 0; cyc < 60 && nr < 6; cyc++) begin
            #1;
            if (bus.req_ready != '0 && ng < 6) begin
                check("rr_grant", 64'(bus.req_ready), 64'(1) << (ng % 3));
                ng++;
            end
            if (bus.rsp_valid) begin
                check("rr_id",  64'(bus.rsp_id), 64'(nr % 3));
                check("rr_res", 64'(bus.rsp_result), 64'(rr_res[nr % 3]));
                nr++;
            end
            @(negedge clk);
        end
        check("rr_count", 64'(nr), 64'(6));
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;

        // backpressure: req0 and req1 valid, last grant 2 -> req0 first
        set_req(0, 32'd100, 32'd23, 4'b0000, 1'b1);
        set_req(1, 32'd5,   32'd6,  4'b0001, 1'b1);
        #1;
        check("bp_grant0", 64'(bus.req_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", 64'(bus.rsp_valid), 64'(1));
            check("bp_res", 64'(bus.rsp_result), 64'(123));
            check("bp_id",  64'(bus.rsp_id), 64'(0));
            check("bp_rdy", 64'(bus.req_ready), 64'(0));
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_grant1", 64'(bus.req_ready), 64'(2));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        check("bp_res1", 64'(bus.rsp_result), 64'(32'hFFFF_FFFF));
        check("bp_id1",  64'(bus.rsp_id), 64'(1));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // reset mid-op: make req0 the last winner, then abort a req1 op in EXEC
        do_op("pre", 0, 32'hFF, 32'h0F, 4'b0010, 32'h0F, 1'b0);
        set_req(1, 32'd1, 32'd1, 4'b0000, 1'b1);
        #1;
        check("rst_grant1", 64'(bus.req_ready), 64'(2));
        @(posedge clk);
        @(negedge clk);
        set_req(0, 32'd3, 32'd4, 4'b0000, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_vld", 64'(bus.rsp_valid), 64'(0));
        check("rst_res", 64'(bus.rsp_result), 64'(0));
        check("rst_id",  64'(bus.rsp_id), 64'(0));
        check("rst_err", 64'(bus.rsp_err), 64'(0));
        check("rst_rdy", 64'(bus.req_ready), 64'(0));
        reset = 1'b0;
        #1;
        check("rst_grant0", 64'(bus.req_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        check("rst_exec_vld", 64'(bus.rsp_valid), 64'(0));
        @(negedge clk);
        check("rst_op_vld", 64'(bus.rsp_valid), 64'(1));
        check("rst_op_id",  64'(bus.rsp_id), 64'(0));
        check("rst_op_res", 64'(bus.rsp_result), 64'(7));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rst_op_done", 64'(bus.rsp_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
